// File: rtl/adder_share_pkg.sv
// Shared types and constants for the two-requester adder sharing block.
// Provides the FSM state enum, default width and requester ids.
package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

endpackage

// File: rtl/add_ovf16.sv
// Combinational WIDTH-bit adder with unsigned carry-out.
// Ports: a, b in; sum = (a+b) mod 2^WIDTH, carry = bit WIDTH of a+b.
module add_ovf16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin sharing of one adder between two valid/ready requesters.
// Ports: clk, rst; req0/req1 valid,a,b,ready; res valid,ready,sum,ovf,id; busy.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter bit PRIO_RESET = ID0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy
);

  state_t state;
  state_t state_nx;

  logic             ptr;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_id;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] add_sum;
  logic             add_c;

  add_ovf16 #(.WIDTH(WIDTH)) u_add (
    .a     (op_a),
    .b     (op_b),
    .sum   (add_sum),
    .carry (add_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Grants exist only in IDLE; on contention the pointer decides.
  always_comb begin
    state_nx = state;
    grant0   = 1'b0;
    grant1   = 1'b0;
    unique case (state)
      IDLE: begin
        grant0 = req0_valid && (!req1_valid || ptr == ID0);
        grant1 = req1_valid && (!req0_valid || ptr == ID1);
        if (grant0 || grant1) state_nx = CALC;
      end
      CALC: state_nx = HOLD;
      HOLD: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == HOLD);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= PRIO_RESET;
      op_a    <= '0;
      op_b    <= '0;
      op_id   <= ID0;
      res_sum <= '0;
      res_ovf <= 1'b0;
      res_id  <= ID0;
    end else begin
      if (grant0) begin
        op_a  <= req0_a;
        op_b  <= req0_b;
        op_id <= ID0;
      end else if (grant1) begin
        op_a  <= req1_a;
        op_b  <= req1_b;
        op_id <= ID1;
      end
      if (state == CALC) begin
        res_sum <= add_sum;
        res_ovf <= add_c;
        res_id  <= op_id;
      end
      // Pointer moves only on an accepted result.
      if (state == HOLD && res_ready) ptr <= ~res_id;
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl.
// Directed steps plus random operands against an arithmetic reference.
module tb_adder_share_ctrl;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_sum;
  logic        res_ovf;
  logic        res_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic ptr_m;

  adder_share_ctrl #(.WIDTH(16), .PRIO_RESET(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_ovf    (res_ovf),
    .res_id     (res_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b0;
    tick();
    rst = 1'b0;
    ptr_m = 1'b0;
    check("rst_valid", res_valid, 0);
    check("rst_sum", res_sum, 0);
    check("rst_ovf", res_ovf, 0);
    check("rst_id", res_id, 0);
    check("rst_busy", busy, 0);
  endtask

  // One full transaction; the model picks the winner from valids + pointer.
  task automatic txn(input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                     input bit v1, input logic [15:0] a1, input logic [15:0] b1,
                     input int stall, output bit won);
    bit w;
    int s;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready = 1'b0;
    #1;
    w = (v0 && v1) ? ptr_m : v1;
    s = w ? (int'(a1) + int'(b1)) : (int'(a0) + int'(b0));
    check("rdy0", req0_ready, (v0 && !w) ? 1 : 0);
    check("rdy1", req1_ready, (v1 && w) ? 1 : 0);
    tick();
    if (w) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
    #1;
    check("calc_busy", busy, 1);
    check("calc_valid", res_valid, 0);
    check("calc_rdy", {req0_ready, req1_ready}, 0);
    tick();
    if (stall > 0) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
    end
    for (int k = 0; k < stall; k++) begin
      #1;
      check("bp_valid", res_valid, 1);
      check("bp_sum", res_sum, s % 65536);
      check("bp_rdy", {req0_ready, req1_ready}, 0);
      tick();
    end
    check("res_valid", res_valid, 1);
    check("res_sum", res_sum, s % 65536);
    check("res_ovf", res_ovf, (s >= 65536) ? 1 : 0);
    check("res_id", res_id, w);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    ptr_m = ~w;
    check("acc_busy", busy, 0);
    check("acc_valid", res_valid, 0);
    won = w;
  endtask

  initial begin
    bit w;
    logic [15:0] pa [2];
    logic [15:0] pb [2];
    bit v0, v1;
    rst = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;
    tick();
    do_reset();

    txn(1, 16'h00C7, 16'h0061, 0, 16'h0, 16'h0, 0, w);
    check("t1_sum", res_sum, 16'h0128);
    txn(1, 16'hFFFF, 16'hFFFF, 0, 16'h0, 16'h0, 0, w);
    check("t2a_sum", res_sum, 16'hFFFE);
    check("t2a_ovf", res_ovf, 1);
    txn(1, 16'hFFFF, 16'h0001, 0, 16'h0, 16'h0, 0, w);
    check("t2b_sum", res_sum, 16'h0000);
    check("t2b_ovf", res_ovf, 1);

    do_reset();
    for (int i = 0; i < 2; i++) begin
      pa[i] = 16'($urandom);
      pb[i] = 16'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      txn(1, pa[0], pb[0], 1, pa[1], pb[1], 0, w);
      check("t3_alt", w, i % 2);
      pa[w] = 16'($urandom);
      pb[w] = 16'($urandom);
    end

    txn(0, 16'h0, 16'h0, 1, 16'h1234, 16'hF00D, 5, w);
    check("t4_id", w, 1);

    for (int i = 0; i < 24; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      txn(v0, 16'($urandom), 16'($urandom),
          v1, 16'($urandom), 16'($urandom),
          int'($urandom_range(0, 2)), w);
    end

    txn(1, 16'h8000, 16'h8000, 0, 16'h0, 16'h0, 0, w);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_busy", busy, 0);
      check("t6_rdy", {req0_ready, req1_ready}, 0);
    end
    req0_valid = 1'b1; req0_a = 16'h0101;
    req1_valid = 1'b1; req1_a = 16'h0202;
    #1;
    check("t6_ptr_rdy1", req1_ready, 1);
    check("t6_ptr_rdy0", req0_ready, 0);
    tick();
    check("t5_calc_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr_m = 1'b0;
    check("t5_valid", res_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_rdy0", req0_ready, 1);
    check("t5_rdy1", req1_ready, 0);
    txn(1, 16'h7FFF, 16'h0001, 1, 16'h0003, 16'h0004, 0, w);
    check("t5_id", w, 0);
    tick();
    check("t5_novalid", res_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
